// File: rtl/dag_host_pkg.sv
// Shared types and constants for the DAG host loader: widths, header layout,
// opcodes and the error response prefix.
package dag_host_pkg;

   localparam int WORD_L          = 32;
   localparam int INSTR_L         = 64;
   localparam int N_BANKS         = 32;
   localparam int DATA_MEM_ADDR_L = 9;
   localparam int INSTR_ADDR_L    = 10;
   localparam int DADDR_L         = $clog2(N_BANKS) + DATA_MEM_ADDR_L;

   localparam int INSTR_BEATS = (INSTR_L + WORD_L - 1) / WORD_L;
   localparam int ASM_L       = INSTR_BEATS * WORD_L;
   localparam int BEAT_W      = (INSTR_BEATS > 1) ? $clog2(INSTR_BEATS) : 1;

   localparam int OP_LSB   = 28;
   localparam int OP_L     = 4;
   localparam int CNT_LSB  = 16;
   localparam int CNT_L    = 12;
   localparam int ADDR_LSB = 0;
   localparam int ADDR_L   = 16;

   localparam logic [WORD_L-1:0] ERR_PREFIX = 32'hE000_0000;

   typedef enum logic [OP_L-1:0] {
      OP_WR_INSTR = 4'd1,
      OP_WR_DATA  = 4'd2,
      OP_RD_DATA  = 4'd3,
      OP_RUN      = 4'd4,
      OP_PING     = 4'd5
   } loader_op_t;

   typedef struct packed {
      logic [OP_L-1:0]   op;
      logic [CNT_L-1:0]  cnt;
      logic [ADDR_L-1:0] addr;
   } hdr_t;

   function automatic hdr_t unpack_hdr(input logic [WORD_L-1:0] w);
      hdr_t h;
      h.op   = w[OP_LSB   +: OP_L];
      h.cnt  = w[CNT_LSB  +: CNT_L];
      h.addr = w[ADDR_LSB +: ADDR_L];
      return h;
   endfunction

   function automatic logic op_known(input logic [OP_L-1:0] op);
      return (op >= OP_WR_INSTR) && (op <= OP_PING);
   endfunction

endpackage

// File: rtl/dag_rsp_slot.sv
// Single-entry valid/ready response register; can_load says a new word may be
// written this cycle (slot empty, or being drained by the host right now).
module dag_rsp_slot
   import dag_host_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_L-1:0] load_data,
   input  logic              rsp_ready,
   output logic [WORD_L-1:0] rsp_data,
   output logic              rsp_valid,
   output logic              can_load
);

   assign can_load = !rsp_valid || rsp_ready;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else if (load && can_load) begin
         rsp_valid <= 1'b1;
         rsp_data  <= load_data;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dag_host_loader.sv
// Host-side sequencer: decodes command headers and drives the DAG processor's
// instruction/data init ports, bank select and run control.
module dag_host_loader
   import dag_host_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WORD_L-1:0]       cmd_data,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   output logic [WORD_L-1:0]       rsp_data,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    enable_execution,
   output logic [INSTR_L-1:0]      init_instr,
   output logic [INSTR_ADDR_L-1:0] init_instr_addr,
   output logic                    init_instr_we,
   output logic                    io_ping_wr,
   input  logic [INSTR_ADDR_L-1:0] current_instr_rd_addr,
   output logic [WORD_L-1:0]       init_data_in,
   input  logic [WORD_L-1:0]       init_data_out,
   output logic [DADDR_L-1:0]      init_data_addr,
   output logic                    init_data_we,
   output logic                    init_data_re
);

   typedef enum logic [2:0] {S_IDLE, S_WI, S_WD, S_RD, S_RUN, S_ERR} state_t;

   state_t              state, state_nxt;
   hdr_t                hdr_in;
   logic [ADDR_L-1:0]   base_q;
   logic [CNT_L-1:0]    cnt_q;
   logic [CNT_L:0]      idx_q, dlv_q, pend_idx_q;
   logic                pend_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [ASM_L-1:0]    asm_q, asm_nxt;
   logic [WORD_L-1:0]   run_cnt_q;
   logic [DADDR_L-1:0]  wr_addr_q;
   logic                cmd_fire, hdr_fire, beat_fire, rsp_fire, can_load;
   logic                instr_done, last_idx, rd_more, rd_capture, run_hit;
   logic                slot_load;
   logic [WORD_L-1:0]   slot_data;

   assign hdr_in     = unpack_hdr(cmd_data);
   assign cmd_ready  = !rst && !rsp_valid && (state == S_IDLE || state == S_WI || state == S_WD);
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign hdr_fire   = cmd_fire && (state == S_IDLE);
   assign beat_fire  = cmd_fire && (state == S_WI || state == S_WD);
   assign rsp_fire   = rsp_valid && rsp_ready;
   assign instr_done = (beat_q == BEAT_W'(INSTR_BEATS - 1));
   assign last_idx   = (idx_q == {1'b0, cnt_q});
   assign rd_more    = (idx_q <= {1'b0, cnt_q});
   assign run_hit    = (state == S_RUN) && enable_execution &&
                       (current_instr_rd_addr == INSTR_ADDR_L'(base_q));

   // A read is issued only if its data can be captured next cycle; if the host
   // then stalls, the in-flight word is dropped and re-read (replay by index).
   assign init_data_re   = (state == S_RD) && rd_more && can_load;
   assign rd_capture     = pend_q && can_load;
   assign init_data_addr = init_data_re ? DADDR_L'(base_q + ADDR_L'(idx_q)) : wr_addr_q;

   dag_rsp_slot u_rsp_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load),
      .load_data (slot_data),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_valid (rsp_valid),
      .can_load  (can_load)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      slot_load = 1'b0;
      slot_data = '0;
      if (rd_capture) begin
         slot_load = 1'b1;
         slot_data = init_data_out;
      end else if (run_hit) begin
         slot_load = 1'b1;
         slot_data = run_cnt_q + 32'd1;
      end else if (hdr_fire && !op_known(hdr_in.op)) begin
         slot_load = 1'b1;
         slot_data = ERR_PREFIX | WORD_L'(hdr_in.op);
      end
      case (state)
         S_IDLE:
            if (hdr_fire) begin
               case (hdr_in.op)
                  OP_WR_INSTR: state_nxt = S_WI;
                  OP_WR_DATA:  state_nxt = S_WD;
                  OP_RD_DATA:  state_nxt = S_RD;
                  OP_RUN:      state_nxt = S_RUN;
                  OP_PING:     state_nxt = S_IDLE;
                  default:     state_nxt = S_ERR;
               endcase
            end
         S_WI:  if (beat_fire && instr_done && last_idx) state_nxt = S_IDLE;
         S_WD:  if (beat_fire && last_idx) state_nxt = S_IDLE;
         S_RD:  if (rsp_fire && dlv_q == {1'b0, cnt_q}) state_nxt = S_IDLE;
         S_RUN: if (!enable_execution && rsp_fire) state_nxt = S_IDLE;
         S_ERR: if (rsp_fire) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Each instruction starts from zero so a short final beat is zero-extended.
   always_comb begin
      asm_nxt = (beat_q == '0) ? '0 : asm_q;
      asm_nxt[int'(beat_q) * WORD_L +: WORD_L] = cmd_data;
   end

   // NOTE: the assembly register needs no reset; it is cleared by the first beat.
   always_ff @(posedge clk) begin
      if (beat_fire && state == S_WI) asm_q <= asm_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q           <= '0;
         cnt_q            <= '0;
         idx_q            <= '0;
         dlv_q            <= '0;
         pend_q           <= 1'b0;
         pend_idx_q       <= '0;
         beat_q           <= '0;
         run_cnt_q        <= '0;
         wr_addr_q        <= '0;
         enable_execution <= 1'b0;
         io_ping_wr       <= 1'b0;
         init_instr       <= '0;
         init_instr_addr  <= '0;
         init_instr_we    <= 1'b0;
         init_data_in     <= '0;
         init_data_we     <= 1'b0;
      end else begin
         init_instr_we <= 1'b0;
         init_data_we  <= 1'b0;

         if (hdr_fire) begin
            base_q    <= hdr_in.addr;
            cnt_q     <= hdr_in.cnt;
            idx_q     <= '0;
            dlv_q     <= '0;
            pend_q    <= 1'b0;
            beat_q    <= '0;
            run_cnt_q <= '0;
            if (hdr_in.op == OP_PING) io_ping_wr <= hdr_in.addr[0];
            if (hdr_in.op == OP_RUN)  enable_execution <= 1'b1;
         end

         if (beat_fire && state == S_WD) begin
            init_data_we <= 1'b1;
            init_data_in <= cmd_data;
            wr_addr_q    <= DADDR_L'(base_q + ADDR_L'(idx_q));
            idx_q        <= idx_q + 1'b1;
         end

         if (beat_fire && state == S_WI) begin
            beat_q <= instr_done ? '0 : beat_q + 1'b1;
            if (instr_done) begin
               init_instr_we   <= 1'b1;
               init_instr      <= asm_nxt[INSTR_L-1:0];
               init_instr_addr <= INSTR_ADDR_L'(base_q + ADDR_L'(idx_q));
               idx_q           <= idx_q + 1'b1;
            end
         end

         if (state == S_RD) begin
            pend_q     <= init_data_re;
            pend_idx_q <= idx_q;
            if (init_data_re)                idx_q <= idx_q + 1'b1;
            else if (pend_q && !can_load)    idx_q <= pend_idx_q;
            if (rsp_fire)                    dlv_q <= dlv_q + 1'b1;
         end

         if (state == S_RUN && enable_execution) begin
            run_cnt_q <= run_cnt_q + 32'd1;
            if (run_hit) enable_execution <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dag_host_loader.sv
// Directed self-checking bench for dag_host_loader with scoreboards for
// instruction writes, data writes and responses.
module tb_dag_host_loader;
   import dag_host_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [WORD_L-1:0]       cmd_data;
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [WORD_L-1:0]       rsp_data;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic                    enable_execution;
   logic [INSTR_L-1:0]      init_instr;
   logic [INSTR_ADDR_L-1:0] init_instr_addr;
   logic                    init_instr_we;
   logic                    io_ping_wr;
   logic [INSTR_ADDR_L-1:0] current_instr_rd_addr;
   logic [WORD_L-1:0]       init_data_in;
   logic [WORD_L-1:0]       init_data_out;
   logic [DADDR_L-1:0]      init_data_addr;
   logic                    init_data_we;
   logic                    init_data_re;

   typedef struct packed {
      logic [INSTR_ADDR_L-1:0] addr;
      logic [INSTR_L-1:0]      instr;
   } wi_exp_t;

   typedef struct packed {
      logic [DADDR_L-1:0] addr;
      logic [WORD_L-1:0]  data;
   } wd_exp_t;

   wi_exp_t           wi_q[$];
   wd_exp_t           wd_q[$];
   logic [WORD_L-1:0] rsp_q[$];

   int                n_checks = 0;
   int                n_fail   = 0;
   int                pc_cnt   = 0;
   int                en_cycles = 0;
   int                en_start;
   logic [WORD_L-1:0] mem_out = '0;

   always #5 clk = ~clk;

   dag_host_loader dut (
      .clk                   (clk),
      .rst                   (rst),
      .cmd_data              (cmd_data),
      .cmd_valid             (cmd_valid),
      .cmd_ready             (cmd_ready),
      .rsp_data              (rsp_data),
      .rsp_valid             (rsp_valid),
      .rsp_ready             (rsp_ready),
      .enable_execution      (enable_execution),
      .init_instr            (init_instr),
      .init_instr_addr       (init_instr_addr),
      .init_instr_we         (init_instr_we),
      .io_ping_wr            (io_ping_wr),
      .current_instr_rd_addr (current_instr_rd_addr),
      .init_data_in          (init_data_in),
      .init_data_out         (init_data_out),
      .init_data_addr        (init_data_addr),
      .init_data_we          (init_data_we),
      .init_data_re          (init_data_re)
   );

   // Data memory model: word at flat address a reads as a + 0x100, one cycle after re.
   always @(posedge clk)
      mem_out <= init_data_re ? (WORD_L'(init_data_addr) + 32'h100) : 32'hDEAD_BEEF;
   assign init_data_out = mem_out;

   // PC model: reaches 0x20 during the 50th enabled cycle of a run.
   always @(posedge clk)
      pc_cnt <= enable_execution ? pc_cnt + 1 : 0;
   assign current_instr_rd_addr = (pc_cnt >= 49) ? INSTR_ADDR_L'(32'h20) : '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (enable_execution) en_cycles++;
      if (init_instr_we) begin
         check("wi_expected", wi_q.size() != 0, 1);
         if (wi_q.size() != 0) begin
            wi_exp_t e;
            e = wi_q.pop_front();
            check("wi_addr", init_instr_addr, e.addr);
            check("wi_instr", init_instr, e.instr);
         end
      end
      if (init_data_we) begin
         check("wd_expected", wd_q.size() != 0, 1);
         if (wd_q.size() != 0) begin
            wd_exp_t e;
            e = wd_q.pop_front();
            check("wd_addr", init_data_addr, e.addr);
            check("wd_data", init_data_in, e.data);
         end
      end
      if (init_data_re) begin
         check("re_slot_free", rsp_valid && !rsp_ready, 0);
         check("re_we_excl", init_data_we, 0);
      end
      if (rsp_valid && rsp_ready) begin
         check("rsp_expected", rsp_q.size() != 0, 1);
         if (rsp_q.size() != 0) check("rsp_data", rsp_data, rsp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WORD_L-1:0] w);
      bit ok = 1'b0;
      cmd_data  = w;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = cmd_ready;
         tick();
      end
      cmd_valid = 1'b0;
      check("cmd_accept", ok, 1);
   endtask

   task automatic drain(input bit toggle, input int budget);
      int n = 0;
      while ((rsp_q.size() != 0 || wi_q.size() != 0 || wd_q.size() != 0) && n < budget) begin
         tick();
         if (toggle) rsp_ready = ~rsp_ready;
         n++;
      end
      rsp_ready = 1'b1;
      check("drain_rsp", rsp_q.size(), 0);
      check("drain_wi", wi_q.size(), 0);
      check("drain_wd", wd_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      cmd_data  = '0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_enable", enable_execution, 0);
      check("reset_ping", io_ping_wr, 0);
      check("reset_strobes", {init_instr_we, init_data_we, init_data_re}, 0);

      // Instruction load: two 64-bit instructions from four beats.
      wi_q.push_back('{addr: 10'h010, instr: 64'h0000_0022_0000_0011});
      wi_q.push_back('{addr: 10'h011, instr: 64'h0000_0044_0000_0033});
      send(32'h1001_0010);
      send(32'h11); send(32'h22); send(32'h33); send(32'h44);
      drain(1'b0, 20);

      // Data load wrapping across the top of the flat address space.
      wd_q.push_back('{addr: 14'h3FFF, data: 32'hA0});
      wd_q.push_back('{addr: 14'h0000, data: 32'hA1});
      wd_q.push_back('{addr: 14'h0001, data: 32'hA2});
      send(32'h2002_3FFF);
      send(32'hA0); send(32'hA1); send(32'hA2);
      drain(1'b0, 20);

      // Read-back with a stalling host.
      for (int i = 0; i < 4; i++) rsp_q.push_back(32'h100 + i);
      send(32'h3003_0000);
      drain(1'b1, 100);
      tick();
      check("rd_back_idle", cmd_ready, 1);

      // Run until the PC model reaches 0x20.
      rsp_q.push_back(32'd50);
      en_start = en_cycles;
      send(32'h4000_0020);
      drain(1'b0, 200);
      tick();
      check("run_enable_cycles", en_cycles - en_start, 50);
      check("run_enable_low", enable_execution, 0);

      // Unknown opcode.
      rsp_q.push_back(32'hE000_0009);
      send(32'h9000_0000);
      drain(1'b0, 20);
      check("err_back_idle", cmd_ready, 1);

      send(32'h5000_0001);
      check("ping_set", io_ping_wr, 1);
      send(32'h5000_0000);
      check("ping_clear", io_ping_wr, 0);
      send(32'h5000_0001);

      // Reset in the middle of a data burst; the third beat must never be written.
      wd_q.push_back('{addr: 14'h0100, data: 32'h55});
      wd_q.push_back('{addr: 14'h0101, data: 32'h66});
      send(32'h2005_0100);
      send(32'h55); send(32'h66);
      cmd_data  = 32'h77;
      cmd_valid = 1'b1;
      rst       = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("wd_rst_strobes", {init_instr_we, init_data_we, init_data_re}, 0);
      check("wd_rst_enable", enable_execution, 0);
      check("wd_rst_rsp_valid", rsp_valid, 0);
      check("wd_rst_ping", io_ping_wr, 0);
      rst = 1'b0;
      tick();
      check("wd_rst_cmd_ready", cmd_ready, 1);
      drain(1'b0, 5);

      // Reset in the middle of a run.
      send(32'h5000_0001);
      send(32'h4000_0020);
      repeat (10) tick();
      check("run_mid_enabled", enable_execution, 1);
      rst = 1'b1;
      tick();
      check("run_rst_enable", enable_execution, 0);
      check("run_rst_rsp_valid", rsp_valid, 0);
      check("run_rst_ping", io_ping_wr, 0);
      check("run_rst_strobes", {init_instr_we, init_data_we, init_data_re}, 0);
      rst = 1'b0;
      tick();
      check("run_rst_cmd_ready", cmd_ready, 1);

      // Normal operation resumes after reset.
      rsp_q.push_back(32'h105);
      send(32'h3000_0005);
      drain(1'b0, 20);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
